bit_destuff: RTL and testbench
==============================

Name: bit_destuff

Overview:
Serial HDLC-style bit de-stuffer. It sits directly downstream of the bit stuffer and consumes that block's valid_stuffed / stuffed_data stream. After RUN_LEN consecutive 1s it removes the inserted 0, restoring the original bit sequence. It flags a stuffing violation when the bit after RUN_LEN ones is a 1, and keeps a saturating count of removed bits for debug.

Parameters:
RUN_LEN, 5, number of consecutive 1s after which a stuffed 0 is expected (legal range 2..15)
CNT_W, 16, width of the drop_cnt statistics counter

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
valid_stuffed  input  1  input bit qualifier from the stuffer
stuffed_data  input  1  stuffed serial bit; sampled only when valid_stuffed=1
clr_cnt  input  1  synchronous clear of drop_cnt and err_cnt
valid_out  output  1  data_out carries a de-stuffed payload bit
data_out  output  1  de-stuffed serial bit
stuff_err  output  1  one-cycle pulse: 1 seen where a stuffed 0 was required
drop_cnt  output  CNT_W  number of stuffed 0s removed (saturating)
err_cnt  output  CNT_W  number of violations (saturating)

Behaviour:
- Reset (rst=0, asynchronous): valid_out=0, data_out=0, stuff_err=0, drop_cnt=0, err_cnt=0, run counter=0, state=IDLE.
- Run counter is $clog2(RUN_LEN+1) bits wide. It counts consecutive accepted 1s within the current valid burst.
- States:
  - IDLE: waiting for valid_stuffed.
  - COUNT: passing bits through.
  - CHECK: the last RUN_LEN accepted bits were 1; the next valid bit is the stuff slot.
- Transitions:
  - IDLE→COUNT on valid_stuffed=1; that bit is processed as in COUNT.
  - COUNT, valid bit=1: output it; run+1. If run reaches RUN_LEN → CHECK.
  - COUNT, valid bit=0: output it; run=0.
  - CHECK, valid bit=0: drop it. valid_out=0 that cycle; drop_cnt+1; run=0 → COUNT.
  - CHECK, valid bit=1: violation. Drop it; stuff_err=1 for one cycle; err_cnt+1; run=0 → COUNT.
  - Any state, valid_stuffed=0: valid_out=0, run=0 → IDLE. A gap ends the burst; a pending CHECK is abandoned with no error.
- Latency: registered, 1 cycle. An input sampled on edge N appears on valid_out/data_out after edge N. stuff_err is aligned to the same slot.
- data_out holds its last value when valid_out=0.
- Counters saturate at all-ones and never wrap.
- clr_cnt=1 zeroes both counters on the next edge. It takes priority over a simultaneous increment. It does not affect the datapath.
- Reset asserted mid-burst: everything returns to reset values immediately. On release the FSM is in IDLE and the first valid bit starts a fresh run.
- There is no back-pressure. One input bit is accepted per valid cycle.

Test Plan:
- Reset check: rst=0 for 2 cycles with random inputs → all outputs 0, counters 0. Release, then 4 idle cycles → outputs remain 0.
- 32 ones through the upstream stuffer: 38-bit stream, with 0s after ones #5, 10, 15, 20, 25, 30, fed continuously with valid_stuffed=1 → exactly 32 valid_out=1 cycles, all data_out=1. valid_out=0 on the 6 stuff slots; drop_cnt=6, stuff_err never asserted.
- Violation: stream 1,1,1,1,1,1,0,1 → first five ones output; sixth bit dropped with stuff_err pulse; err_cnt=1; then 0,1 output normally; drop_cnt=0.
- Gap clears run: 1,1,1,1, valid low 1 cycle, then 1,1,0 → all seven bits output (no drop), drop_cnt=0, stuff_err=0.
- Reset mid-run: after 4 ones, assert rst for 1 cycle, release, then feed 1,1,1,1,1,0 → five ones output, 0 dropped, drop_cnt=1.
- Saturation and clear (CNT_W=2): feed 5 stuffed-zero events → drop_cnt stays 3. Pulse clr_cnt coincident with a 6th drop → drop_cnt=0 after the edge.

Source files
------------

// File: rtl/bit_destuff.sv
// Serial HDLC-style bit de-stuffer: removes the 0 inserted after RUN_LEN ones,
// flags a 1 in the stuff slot, and keeps saturating drop/error statistics.
module bit_destuff #(
    parameter int unsigned RUN_LEN = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_stuffed,
    input  logic             stuffed_data,
    input  logic             clr_cnt,
    output logic             valid_out,
    output logic             data_out,
    output logic             stuff_err,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] run, run_n;
    logic          valid_n, data_n, err_n;
    logic          drop_inc, err_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            run       <= '0;
            valid_out <= 1'b0;
            data_out  <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            valid_out <= valid_n;
            data_out  <= data_n;
            stuff_err <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        run_n    = run;
        valid_n  = 1'b0;
        data_n   = data_out;
        err_n    = 1'b0;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        if (!valid_stuffed) begin
            // a gap ends the burst; any pending stuff slot is abandoned silently
            state_n = IDLE;
            run_n   = '0;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    valid_n = 1'b1;
                    data_n  = stuffed_data;
                    state_n = COUNT;
                    if (stuffed_data) begin
                        run_n = run + 1'b1;
                        if (run + 1'b1 == RUN_MAX)
                            state_n = CHECK;
                    end else begin
                        run_n = '0;
                    end
                end
                CHECK: begin
                    run_n   = '0;
                    state_n = COUNT;
                    if (stuffed_data) begin
                        err_n   = 1'b1;
                        err_inc = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    run_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr_cnt) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (drop_inc && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            if (err_inc && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_destuff.sv
// Directed bench for bit_destuff: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_bit_destuff;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        vo, dout, serr;
    logic [15:0] dcnt, ecnt;
    logic        s_vo, s_dout, s_serr;
    logic [1:0]  s_dcnt, s_ecnt;

    int errors = 0;
    int checks = 0;
    int nvalid = 0;

    always #5 clk = ~clk;

    bit_destuff #(.RUN_LEN(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_stuffed(vin), .stuffed_data(din),
        .clr_cnt(clr), .valid_out(vo), .data_out(dout), .stuff_err(serr),
        .drop_cnt(dcnt), .err_cnt(ecnt)
    );

    bit_destuff #(.RUN_LEN(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .valid_stuffed(vin), .stuffed_data(din),
        .clr_cnt(clr), .valid_out(s_vo), .data_out(s_dout), .stuff_err(s_serr),
        .drop_cnt(s_dcnt), .err_cnt(s_ecnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle, then check the registered result one edge later.
    task automatic push(input logic v, input logic d, input logic evo,
                        input logic edo, input logic eerr, input string tag);
        vin = v;
        din = d;
        @(posedge clk);
        #1;
        if (vo === 1'b1) nvalid++;
        check({tag, "/valid_out"}, 32'(vo), 32'(evo));
        check({tag, "/data_out"}, 32'(dout), 32'(edo));
        check({tag, "/stuff_err"}, 32'(serr), 32'(eerr));
    endtask

    // Idle cycle with clr_cnt high; both counters must read zero afterwards.
    task automatic clear(input logic hold_do, input string tag);
        clr = 1'b1;
        push(1'b0, 1'b0, 1'b0, hold_do, 1'b0, tag);
        clr = 1'b0;
        check({tag, "/drop_cnt"}, 32'(dcnt), 32'd0);
        check({tag, "/err_cnt"}, 32'(ecnt), 32'd0);
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            vin = 1'($urandom);
            din = 1'($urandom);
            clr = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst/valid_out", 32'(vo), 32'd0);
            check("rst/data_out", 32'(dout), 32'd0);
            check("rst/stuff_err", 32'(serr), 32'd0);
            check("rst/drop_cnt", 32'(dcnt), 32'd0);
            check("rst/err_cnt", 32'(ecnt), 32'd0);
        end
        vin = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // 32 ones stuffed upstream: 0 after every fifth one
        nvalid = 0;
        for (int i = 1; i <= 32; i++) begin
            push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "ones32/one");
            if (i % 5 == 0) push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "ones32/slot");
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ones32/gap");
        check("ones32/nvalid", 32'(nvalid), 32'd32);
        check("ones32/drop_cnt", 32'(dcnt), 32'd6);
        check("ones32/err_cnt", 32'(ecnt), 32'd0);
        check("ones32/sat_drop_cnt", 32'(s_dcnt), 32'd3);

        // Violation: 1 in the stuff slot
        clear(1'b1, "viol/clr");
        for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "viol/one");
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "viol/slot");
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "viol/zero");
        push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "viol/tail");
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "viol/gap");
        check("viol/err_cnt", 32'(ecnt), 32'd1);
        check("viol/drop_cnt", 32'(dcnt), 32'd0);

        // A gap resets the run
        clear(1'b1, "gap/clr");
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "gap/pre");
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "gap/hole");
        push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "gap/post1");
        push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "gap/post2");
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "gap/post0");
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap/end");
        check("gap/drop_cnt", 32'(dcnt), 32'd0);
        check("gap/err_cnt", 32'(ecnt), 32'd0);

        // Reset mid-run
        clear(1'b0, "mid/clr");
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid/pre");
        rst = 1'b0;
        #1;
        check("mid/async_valid_out", 32'(vo), 32'd0);
        check("mid/async_data_out", 32'(dout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid/one");
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "mid/slot");
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mid/gap");
        check("mid/drop_cnt", 32'(dcnt), 32'd1);

        // Saturation on the CNT_W=2 instance, then clear racing a drop
        clear(1'b1, "sat/clr");
        check("sat/clr_sat", 32'(s_dcnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "sat/one");
            push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "sat/slot");
            if (k == 2) check("sat/three", 32'(s_dcnt), 32'd3);
        end
        check("sat/held", 32'(s_dcnt), 32'd3);
        check("sat/wide_cnt", 32'(dcnt), 32'd5);
        for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "sat/one6");
        clr = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "sat/slot6");
        clr = 1'b0;
        check("sat/clr_prio", 32'(s_dcnt), 32'd0);
        check("sat/clr_prio_wide", 32'(dcnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
